// File: rtl/msf_frame_assembler_if.sv
// msf_frame_assembler_if: decoder bit stream in, validated time-of-day frame out
interface msf_frame_if;
    logic       bits_valid_i;
    logic       bits_is_second_00_i;
    logic [1:0] bits_data_i;
    logic       time_valid_o;
    logic [7:0] year_o;
    logic [4:0] month_o;
    logic [5:0] day_o;
    logic [2:0] dow_o;
    logic [5:0] hour_o;
    logic [6:0] minute_o;
    logic       frame_strobe_o;
    logic       frame_err_o;
    logic [5:0] second_o;

    modport slave (
        input  bits_valid_i, bits_is_second_00_i, bits_data_i,
        output time_valid_o, year_o, month_o, day_o, dow_o, hour_o, minute_o,
               frame_strobe_o, frame_err_o, second_o
    );

    modport master (
        output bits_valid_i, bits_is_second_00_i, bits_data_i,
        input  time_valid_o, year_o, month_o, day_o, dow_o, hour_o, minute_o,
               frame_strobe_o, frame_err_o, second_o
    );
endinterface

// File: rtl/msf_frame_assembler.sv
// msf_frame_assembler: checks MSF frames (length, marker, parity) and locks time after consecutive good frames
module msf_frame_assembler #(
    parameter int FRAME_MIN    = 59,
    parameter int FRAME_MAX    = 61,
    parameter int CHECK_PARITY = 1,
    parameter int GOOD_FRAMES  = 2
) (
    input logic        clk_i,
    input logic        rst_i,
    msf_frame_if.slave bus
);
    logic        synced_q, synced_d;
    logic [5:0]  sec_cnt_q, sec_cnt_d;
    logic [42:0] sa_q, sa_d;
    logic [5:0]  sb_q, sb_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic [34:0] fields_q, fields_d;
    logic        strobe_q, strobe_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;
    logic        data_pulse, s00_pulse, eval, len_ok, mark_ok, par_ok, good;
    logic [6:0]  len;

    assign data_pulse = bus.bits_valid_i & ~bus.bits_is_second_00_i;
    assign s00_pulse  = bus.bits_valid_i & bus.bits_is_second_00_i;
    assign eval       = s00_pulse & synced_q;

    // Frame judgement from the pre-update shift registers, plus all next-state values
    always_comb begin
        len        = {1'b0, sec_cnt_q} + 7'd1;
        len_ok     = (len >= 7'(FRAME_MIN)) && (len <= 7'(FRAME_MAX));
        mark_ok    = sa_q[7:0] == 8'b01111110;
        par_ok     = (CHECK_PARITY == 0) ||
                     ((^{sa_q[42:35], sb_q[5]}) & (^{sa_q[34:24], sb_q[4]}) &
                      (^{sa_q[23:21], sb_q[3]}) & (^{sa_q[20:8], sb_q[2]}));
        good       = len_ok & mark_ok & par_ok;
        synced_d   = synced_q | s00_pulse;
        sec_cnt_d  = s00_pulse ? 6'd0 :
                     data_pulse ? ((sec_cnt_q == 6'd63) ? sec_cnt_q : sec_cnt_q + 6'd1) : sec_cnt_q;
        sa_d       = s00_pulse ? '0 : data_pulse ? {sa_q[41:0], bus.bits_data_i[1]} : sa_q;
        sb_d       = s00_pulse ? '0 : data_pulse ? {sb_q[4:0], bus.bits_data_i[0]} : sb_q;
        good_cnt_d = !eval ? good_cnt_q :
                     !good ? 4'd0 :
                     (good_cnt_q == 4'(GOOD_FRAMES)) ? good_cnt_q : good_cnt_q + 4'd1;
        fields_d   = (eval & good) ? sa_q[42:8] : fields_q;
        strobe_d   = eval & good;
        err_d      = eval & ~good;
        valid_d    = good_cnt_d == 4'(GOOD_FRAMES);
    end

    // State registers; reset drops any frame in progress and any coincident pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            synced_q   <= 1'b0;
            sec_cnt_q  <= '0;
            sa_q       <= '0;
            sb_q       <= '0;
            good_cnt_q <= '0;
            fields_q   <= '0;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            synced_q   <= synced_d;
            sec_cnt_q  <= sec_cnt_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            good_cnt_q <= good_cnt_d;
            fields_q   <= fields_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.time_valid_o   = valid_q;
    assign bus.year_o         = fields_q[34:27];
    assign bus.month_o        = fields_q[26:22];
    assign bus.day_o          = fields_q[21:16];
    assign bus.dow_o          = fields_q[15:13];
    assign bus.hour_o         = fields_q[12:7];
    assign bus.minute_o       = fields_q[6:0];
    assign bus.frame_strobe_o = strobe_q;
    assign bus.frame_err_o    = err_q;
    assign bus.second_o       = sec_cnt_q;
endmodule

// File: doc/msf_frame_assembler.md
# msf_frame_assembler

Assembles one-bit-pair-per-second output from the MSF decoder into a validated time-of-day frame: year, month, day, day-of-week, hour and minute in BCD. Sits directly downstream of `decoder` in the MSF clock top, consuming its `bits_valid` / `bits_is_second_00` / `bits_data` stream. Generalises the raw bit stream with:
- frame-length checking, including leap-second minutes;
- marker and parity checking;
- a consecutive-good-frame lock qualifier before time is declared valid.

## Interface
Parameters:
- `FRAME_MIN`, default 59: shortest accepted frame in seconds, second 00 included.
- `FRAME_MAX`, default 61: longest accepted frame in seconds. Must satisfy 44 ≤ `FRAME_MIN` ≤ `FRAME_MAX` ≤ 63.
- `CHECK_PARITY`, default 1: 1 means parity failures reject the frame; 0 means parity is ignored.
- `GOOD_FRAMES`, default 2, range 1..15: number of consecutive good frames required before `time_valid_o` asserts.

Ports:
- `clk_i` in 1: system clock. One clock domain; reset is synchronous and active-high.
- `rst_i` in 1: synchronous active-high reset.
- `bits_valid_i` in 1: one-cycle pulse, one per received second.
- `bits_is_second_00_i` in 1: qualifies `bits_valid_i`; marks second 00, the frame start.
- `bits_data_i` in 2: bit 1 is MSF A bit, bit 0 is MSF B bit. Ignored on second-00 pulses.
- `time_valid_o` out 1: time fields locked and trustworthy.
- `year_o` out 8: BCD 00–99.
- `month_o` out 5: BCD 01–12.
- `day_o` out 6: BCD 01–31.
- `dow_o` out 3: day of week, 0–6.
- `hour_o` out 6: BCD 00–23.
- `minute_o` out 7: BCD 00–59.
- `frame_strobe_o` out 1: one-cycle pulse when a good frame is accepted.
- `frame_err_o` out 1: one-cycle pulse when a frame is rejected.
- `second_o` out 6: seconds elapsed since the last second 00. Saturates at 63.

## Operation
- **State.**
  - `synced` flag.
  - 6-bit `sec_cnt`.
  - 43-bit A shift register `sa`.
  - 6-bit B shift register `sb`.
  - 4-bit `good_cnt`.
- **Data pulse** (`bits_valid_i` & !`bits_is_second_00_i`):
  - `sa <= {sa[41:0], A}`, `sb <= {sb[4:0], B}`.
  - `sec_cnt` increments, saturating at 63.
  - Indexing is from the end of the frame: `sa[k]` holds second 59−k. Leap seconds inserted earlier in the minute therefore need no special handling.
- **Second-00 pulse** (`bits_valid_i` & `bits_is_second_00_i`):
  - If `synced` = 0: set `synced`. No evaluation, no strobe, no error.
  - If `synced` = 1: evaluate the frame from the pre-update `sa`/`sb`/`sec_cnt`.
  - In both cases: clear `sec_cnt`, `sa` and `sb`.
- **Field mapping.**
  - `year` = `sa[42:35]`.
  - `month` = `sa[34:30]`.
  - `day` = `sa[29:24]`.
  - `dow` = `sa[23:21]`.
  - `hour` = `sa[20:15]`.
  - `minute` = `sa[14:8]`.
  - Marker = `sa[7:0]`, seconds 52..59.
- **Frame is good iff all of the following hold:**
  - `FRAME_MIN` ≤ `sec_cnt`+1 ≤ `FRAME_MAX`.
  - `sa[7:0]` == 8'b01111110.
  - If `CHECK_PARITY`, odd parity on each group:
    - `^{sa[42:35], sb[5]}` = 1;
    - `^{sa[34:24], sb[4]}` = 1;
    - `^{sa[23:21], sb[3]}` = 1;
    - `^{sa[20:8], sb[2]}` = 1.
- **Good frame:**
  - Load all field outputs.
  - Pulse `frame_strobe_o`.
  - `good_cnt` increments, saturating at `GOOD_FRAMES`.
- **Bad frame:**
  - Fields hold their last values.
  - Pulse `frame_err_o`.
  - `good_cnt` <= 0.
- `time_valid_o` = (`good_cnt` == `GOOD_FRAMES`), registered.
- **Saturation.** A frame that reaches `sec_cnt` = 63 is bad: 64 seconds exceeds any legal `FRAME_MAX`. Shifting continues meanwhile.

## Timing
- **Reset.** All outputs are 0. `synced`, `sec_cnt`, `sa`, `sb` and `good_cnt` are cleared. Reset mid-frame discards the frame; the next second-00 pulse only re-syncs.
- **Latency.**
  - Fields, `frame_strobe_o`, `frame_err_o` and `time_valid_o` update in the cycle after the second-00 pulse (1-cycle latency).
  - `second_o` reads 0 in the cycle after a second-00 pulse and n after the n-th data pulse.
- **Strobe exclusivity.** `frame_strobe_o` and `frame_err_o` are never high together. Neither is high except in that single post-second-00 cycle.
- **Qualification.** Inputs are sampled only when `bits_valid_i` = 1. `bits_is_second_00_i` and `bits_data_i` are don't-care otherwise.
- **Consecutive pulses.** Back-to-back `bits_valid_i` pulses on consecutive cycles are each accepted; no throughput limit.
- **Reset priority.** `rst_i` asserted together with `bits_valid_i` wins; the pulse is dropped.

## Test plan
- **Sync-only first frame.** Reset, then a second-00 pulse followed by 58 data pulses -> no strobe or error on the first second-00 pulse. The frame ending at the second second-00 pulse is evaluated.
- **Normal frame.** Send 2023-03-14, dow 2, 12:34 with correct markers and parity, 59 seconds -> `frame_strobe_o` pulses; `year_o`=8'h23, `month_o`=5'h03, `day_o`=6'h14, `dow_o`=2, `hour_o`=6'h12, `minute_o`=7'h34. `time_valid_o` stays 0 after the first good frame and goes 1 after the second (`GOOD_FRAMES`=2).
- **Leap second.** Same minute as a 61-second frame, with the extra data pulse inserted before second 17 -> accepted with identical fields. A 62-second frame -> `frame_err_o` pulses, `time_valid_o` drops to 0, fields unchanged.
- **Parity.** Flip B bit 57 -> `frame_err_o` pulses. Repeat with `CHECK_PARITY`=0 -> `frame_strobe_o` pulses instead.
- **Marker.** Corrupt the A bit at second 52 to 1 -> `frame_err_o` pulses. The next good frame gives `frame_strobe_o`, but `time_valid_o` stays 0 until `GOOD_FRAMES` consecutive good frames.
- **Reset and saturation.** Assert `rst_i` at second 30 -> all outputs 0 and the following second-00 pulse only syncs. Separately, 70 data pulses without a second 00 -> `second_o` holds 63, and the next second-00 pulse gives `frame_err_o`.
